// File: rtl/rv32_mem_arbiter.sv
// rv32_mem_arbiter
// Shares one single-port, fixed-latency memory between the RV32 fetch port
// and the load/store port. It handles one transaction at a time: arbitrate in
// IDLE, strobe memory in ISSUE, wait MEM_LAT cycles, then respond in RESP.
// Misaligned or out-of-range addresses are answered with an error and never
// reach memory. The fetch port is promoted after STARVE_MAX consecutive losses.
module rv32_mem_arbiter #(
    parameter int unsigned MEM_WORDS  = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,

    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    // Highest legal byte address (last word of the memory).
    localparam logic [31:0] MAX_ADDR = 32'(MEM_WORDS * 4 - 4);
    localparam int unsigned LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int unsigned STV_W    = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t           state;
    logic [STV_W-1:0] starve_cnt;
    logic [LAT_W-1:0] lat_cnt;

    // Attributes of the transaction currently being served.
    logic             win_d;
    logic             win_we;
    logic             win_err;

    // Candidate transaction as seen in IDLE.
    logic             fetch_wins;
    logic [31:0]      sel_addr;
    logic             sel_we;
    logic [31:0]      sel_wdata;
    logic             sel_err;

    // Arbitration and address check for the request pending in IDLE.
    always_comb begin
        fetch_wins = !d_req || (i_req && (starve_cnt == STV_W'(STARVE_MAX)));
        sel_addr   = fetch_wins ? i_addr : d_addr;
        sel_we     = !fetch_wins && d_we;
        sel_wdata  = sel_we ? d_wdata : '0;
        sel_err    = (sel_addr[1:0] != 2'b00) || (sel_addr > MAX_ADDR);
    end

    // Transaction FSM; every output is registered and set on state entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            lat_cnt    <= '0;
            win_d      <= 1'b0;
            win_we     <= 1'b0;
            win_err    <= 1'b0;
            i_gnt      <= 1'b0;
            i_rvalid   <= 1'b0;
            i_rdata    <= '0;
            i_err      <= 1'b0;
            d_gnt      <= 1'b0;
            d_rvalid   <= 1'b0;
            d_rdata    <= '0;
            d_err      <= 1'b0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Losing streak only grows while both ports are asking
                    // and the data port keeps winning.
                    if (!i_req || fetch_wins) begin
                        starve_cnt <= '0;
                    end else if (starve_cnt != STV_W'(STARVE_MAX)) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end

                    if (i_req || d_req) begin
                        win_d   <= !fetch_wins;
                        win_we  <= sel_we;
                        win_err <= sel_err;
                        i_gnt   <= fetch_wins;
                        d_gnt   <= !fetch_wins;
                        // Bad addresses never strobe memory; address and
                        // data lines keep the last legal access.
                        if (!sel_err) begin
                            m_req   <= 1'b1;
                            m_we    <= sel_we;
                            m_addr  <= {2'b00, sel_addr[31:2]};
                            m_wdata <= sel_wdata;
                        end
                        state <= ISSUE;
                    end
                end

                ISSUE: begin
                    i_gnt   <= 1'b0;
                    d_gnt   <= 1'b0;
                    m_req   <= 1'b0;
                    m_we    <= 1'b0;
                    lat_cnt <= '0;
                    if (win_err) begin
                        i_rvalid <= !win_d;
                        d_rvalid <= win_d;
                        i_err    <= !win_d;
                        d_err    <= win_d;
                        state    <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    if (lat_cnt == LAT_W'(MEM_LAT - 1)) begin
                        // Read data is captured straight into the response
                        // register; stores answer with zero data.
                        i_rvalid <= !win_d;
                        d_rvalid <= win_d;
                        if (!win_d) begin
                            i_rdata <= m_rdata;
                        end else if (!win_we) begin
                            d_rdata <= m_rdata;
                        end
                        state <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end

                RESP: begin
                    i_rvalid <= 1'b0;
                    d_rvalid <= 1'b0;
                    i_rdata  <= '0;
                    d_rdata  <= '0;
                    i_err    <= 1'b0;
                    d_err    <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// tb_rv32_mem_arbiter
// Table-driven transactions plus hand-written arbitration, starvation and
// reset sequences. Expected responses go into a scoreboard queue when a
// request is driven and are compared when the DUT raises rvalid.
module tb_rv32_mem_arbiter;

    localparam int unsigned MEM_LAT = 1;
    localparam int unsigned NVEC    = 14;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    rv32_mem_arbiter #(
        .MEM_WORDS (32),
        .MEM_LAT   (MEM_LAT),
        .STARVE_MAX(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_gnt   (i_gnt),
        .i_rvalid(i_rvalid),
        .i_rdata (i_rdata),
        .i_err   (i_err),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_gnt   (d_gnt),
        .d_rvalid(d_rvalid),
        .d_rdata (d_rdata),
        .d_err   (d_err),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 32 words, one cycle read latency, initialised once.
    logic [31:0] mem [32];
    logic        mem_init;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int unsigned i = 0; i < 32; i++) mem[i] <= 32'hC0DE_0000 + 32'(i);
            mem[2] <= 32'h07b0_8113;
        end else if (m_req) begin
            if (m_we) mem[m_addr[4:0]] <= m_wdata;
            else      m_rdata <= mem[m_addr[4:0]];
        end
    end

    typedef struct packed {
        logic        port_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct packed {
        logic        port_d;
        logic [31:0] rdata;
        logic        err;
    } sb_t;

    sb_t  sb[$];
    vec_t vecs[NVEC];
    int   nchk;
    int   nerr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: every rvalid must match the oldest expectation.
    always @(negedge clk) begin : monitor
        sb_t e;
        if (!rst && (i_rvalid || d_rvalid)) begin
            check("rvalid_exclusive", 32'(i_rvalid && d_rvalid), 32'd0);
            check("rvalid_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("resp_port", 32'(d_rvalid), 32'(e.port_d));
                check("resp_rdata", e.port_d ? d_rdata : i_rdata, e.rdata);
                check("resp_err", 32'(e.port_d ? d_err : i_err), 32'(e.err));
                check("other_rdata_zero", e.port_d ? i_rdata : d_rdata, 32'd0);
            end
        end
    end

    // One complete transaction on one port; called at a negedge in IDLE.
    task automatic do_txn(input vec_t v);
        sb_t         e;
        int unsigned lat;
        logic        seen;
        if (v.port_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        e.port_d = v.port_d; e.rdata = v.exp_rdata; e.err = v.exp_err;
        sb.push_back(e);
        @(negedge clk);
        check("gnt", 32'({i_gnt, d_gnt}), v.port_d ? 32'd1 : 32'd2);
        check("m_req", 32'(m_req), 32'(!v.exp_err));
        check("m_we", 32'(m_we), 32'(v.port_d && v.we && !v.exp_err));
        if (!v.exp_err) begin
            check("m_addr", m_addr, v.addr >> 2);
            check("m_wdata", m_wdata, (v.port_d && v.we) ? v.wdata : 32'd0);
        end
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 2) check("m_req_pulse", 32'({m_req, i_gnt, d_gnt}), 32'd0);
            seen = v.port_d ? d_rvalid : i_rvalid;
        end
        check("rvalid_latency", lat, v.exp_err ? 32'd2 : 32'(MEM_LAT + 2));
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int unsigned n;
        logic        exp_d [10];
        sb_t         e;

        nchk = 0;
        nerr = 0;
        //                port  we    addr          wdata         exp_rdata     err
        vecs[0]  = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,         32'h07b0_8113, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 32'h0000_0040, 32'h3,         32'h0,         1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         32'h3,         1'b0};
        vecs[3]  = '{1'b1, 1'b1, 32'h0000_007C, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_007C, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0042, 32'h0,         32'h0,         1'b1};
        vecs[6]  = '{1'b0, 1'b0, 32'h0000_0080, 32'h0,         32'h0,         1'b1};
        vecs[7]  = '{1'b1, 1'b1, 32'h0000_0080, 32'h55,        32'h0,         1'b1};
        vecs[8]  = '{1'b0, 1'b0, 32'h0000_007E, 32'h0,         32'h0,         1'b1};
        vecs[9]  = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b1};
        vecs[10] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'hC0DE_0000, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 32'h0000_0004, 32'h1234_5678, 32'h0,         1'b0};
        vecs[12] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0,         32'h1234_5678, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'hC0DE_0000, 1'b0};

        rst = 1'b1; mem_init = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs_zero", 32'(|{i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid,
              d_rdata, d_err, m_req, m_we, m_addr, m_wdata}), 32'd0);
        rst = 1'b0; mem_init = 1'b0;
        @(negedge clk);

        for (int unsigned k = 0; k < NVEC; k++) do_txn(vecs[k]);

        // Both ports in the same IDLE cycle: data first, fetch 4 cycles later.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        i_req = 1'b1; i_addr = 32'h8;
        e = '{1'b1, 32'h3, 1'b0};         sb.push_back(e);
        e = '{1'b0, 32'h07b0_8113, 1'b0}; sb.push_back(e);
        @(negedge clk);
        check("both_first_gnt", 32'({i_gnt, d_gnt}), 32'd1);
        d_req = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!i_gnt && n < 20);
        check("both_fetch_gnt_delay", n, 32'd4);
        i_req = 1'b0;
        repeat (6) @(negedge clk);

        // Starvation: both held high, fetch promoted every fifth grant.
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        i_req = 1'b1; i_addr = 32'h8;
        for (int unsigned g = 0; g < 10; g++) begin
            e.port_d = exp_d[g];
            e.rdata  = exp_d[g] ? 32'h3 : 32'h07b0_8113;
            e.err    = 1'b0;
            sb.push_back(e);
        end
        for (int unsigned g = 0; g < 10; g++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!(i_gnt || d_gnt) && n < 20);
            check("starve_gnt_spacing", n, (g == 0) ? 32'd1 : 32'(MEM_LAT + 3));
            check("starve_order", 32'({i_gnt, d_gnt}), exp_d[g] ? 32'd1 : 32'd2);
            if (g == 9) begin
                d_req = 1'b0; i_req = 1'b0;
            end
        end
        repeat (6) @(negedge clk);

        // Reset during WAIT of a load abandons it.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        @(negedge clk);
        check("rst_seq_gnt", 32'(d_gnt), 32'd1);
        d_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs_zero", 32'(|{i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid,
              d_rdata, d_err, m_req, m_we, m_addr, m_wdata}), 32'd0);
        rst = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_no_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
        end
        do_txn('{1'b0, 1'b0, 32'h0, 32'h0, 32'hC0DE_0000, 1'b0});

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
